gpio_bank: RTL and testbench
============================

GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 Parameter SW_W, default 8: number of switch input channels (1..DATA_W).
REQ-002 Parameter LED_W, default 8: number of LED output channels (1..DATA_W).
REQ-003 Parameter DATA_W, default 32: CPU data bus width.
REQ-004 Parameter DB_CNT, default 4: stable cycles required before a switch change is accepted (>=1).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 switches  input  SW_W  raw asynchronous switch levels.
REQ-008 leds  output  LED_W  LED drive, direct from LED register.
REQ-009 addr  input  2  register select: 0 SW_STATE (RO), 1 LED (RW), 2 EDGE (RW1C), 3 IRQ_EN (RW).
REQ-010 wr_en  input  1  write strobe, one write per asserted cycle.
REQ-011 wr_data  input  DATA_W  write data.
REQ-012 rd_en  input  1  read strobe.
REQ-013 rd_data  output  DATA_W  registered read data.
REQ-014 rd_valid  output  1  high for one cycle when rd_data is new.
REQ-015 irq  output  1  level interrupt, registered.

Function
REQ-016 Each switch bit SHALL pass through a two-flop synchroniser before any other logic.
REQ-017 Each bit SHALL have an independent debounce counter (width ceil(log2(DB_CNT+1))).
REQ-018 Counter SHALL clear whenever synchronised bit equals debounced bit.
REQ-019 Counter SHALL increment while they differ; at DB_CNT consecutive differing cycles the debounced bit SHALL toggle and counter clear.
REQ-020 A stable input change SHALL appear in SW_STATE at the (DB_CNT+2)th rising edge after it is first sampled; glitches shorter than DB_CNT cycles after synchronisation SHALL be rejected.
REQ-021 A 0->1 transition of a debounced bit SHALL set the matching EDGE bit (sticky).
REQ-022 Write to EDGE SHALL clear each bit where wr_data is 1; set and clear in the same cycle: set wins.
REQ-023 Write to LED SHALL load wr_data[LED_W-1:0]; write to IRQ_EN SHALL load wr_data[SW_W-1:0]; write to SW_STATE SHALL be ignored.
REQ-024 Read latency SHALL be 1 cycle: rd_data and rd_valid=1 on the edge after rd_en=1; rd_valid=0 otherwise; rd_data holds between reads.
REQ-025 Register bits above SW_W/LED_W SHALL read as 0.
REQ-026 Read and write in the same cycle to the same address SHALL return the pre-write value.
REQ-027 irq SHALL equal registered OR of (EDGE & IRQ_EN), i.e. one cycle after either changes.
REQ-028 Back-to-back reads on consecutive cycles SHALL each produce rd_valid, no bubbles.

Reset
REQ-029 While rst_n=0: synchronisers, debounced state, counters, EDGE, IRQ_EN, LED, rd_data, rd_valid, irq SHALL all be 0, taking effect without a clock edge.
REQ-030 Reset asserted mid-debounce or mid-read SHALL abort it; no rd_valid and no EDGE set after release from pre-reset activity.
REQ-031 First debounce evaluation SHALL begin on the first rising edge after rst_n rises.

Verification
REQ-032 Reset, switches=8'h02 held -> SW_STATE reads 8'h02 by edge 6 (DB_CNT=4), EDGE=8'h02, irq=0.
REQ-033 IRQ_EN<=8'h02, switch bit1 0->1 -> irq=1 one cycle after EDGE bit1 sets; write EDGE 8'h02 -> irq=0 next cycle.
REQ-034 Bit0 pulse of 3 synchronised cycles -> SW_STATE bit0 stays 0, EDGE unchanged; 4-cycle pulse -> bit0 toggles.
REQ-035 Write LED 32'hFFFF_FFA5 -> leds=8'hA5 next cycle; read addr 1 -> rd_data=32'h0000_00A5, rd_valid one cycle.
REQ-036 Edge set and W1C of same bit in same cycle -> bit remains 1.
REQ-037 rst_n low mid-operation with LED=8'hA5, EDGE=8'h03 -> leds, EDGE, irq, rd_valid =0 immediately, before next clk edge.

Source files
------------

// File: rtl/gpio_bank.sv
// gpio_bank: debounced switch inputs with sticky rise flags, LED register, and a level IRQ behind a 4-register CPU port.
module gpio_bank #(
    parameter int SW_W   = 8,
    parameter int LED_W  = 8,
    parameter int DATA_W = 32,
    parameter int DB_CNT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SW_W-1:0]   switches,
    output logic [LED_W-1:0]  leds,
    input  logic [1:0]        addr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              irq
);
    localparam int CW = $clog2(DB_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

    logic [SW_W-1:0]   sync1, sync2, deb, deb_nxt, edge_r, edge_nxt, irq_en, edge_clr;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_ok;

    assign unused_ok = ^wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
        end else begin
            sync1 <= switches;
            sync2 <= sync1;
            deb   <= deb_nxt;
        end
    end

    // A bit flips on the DB_CNT-th consecutive cycle its synchronised level disagrees.
    for (genvar i = 0; i < SW_W; i++) begin : g_db
        logic [CW-1:0] cnt;
        logic          flip;
        assign flip       = (sync2[i] != deb[i]) && (cnt == CNT_LAST);
        assign deb_nxt[i] = deb[i] ^ flip;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else
                cnt <= (sync2[i] == deb[i] || flip) ? '0 : cnt + CW'(1);
        end
    end

    always_comb begin
        edge_clr = (wr_en && addr == 2'd2) ? wr_data[SW_W-1:0] : '0;
        edge_nxt = (edge_r & ~edge_clr) | (deb_nxt & ~deb);
        rd_mux   = addr == 2'd0 ? DATA_W'(deb)    :
                   addr == 2'd1 ? DATA_W'(leds)   :
                   addr == 2'd2 ? DATA_W'(edge_r) : DATA_W'(irq_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_r   <= '0;
            irq_en   <= '0;
            leds     <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            irq      <= 1'b0;
        end else begin
            edge_r   <= edge_nxt;
            irq      <= |(edge_r & irq_en);
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_mux;
            if (wr_en && addr == 2'd1)
                leds <= wr_data[LED_W-1:0];
            if (wr_en && addr == 2'd3)
                irq_en <= wr_data[SW_W-1:0];
        end
    end
endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed and random stimulus against a window-based reference model of gpio_bank.
module tb_gpio_bank;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  switches;
    logic [7:0]  leds;
    logic [1:0]  addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        irq;

    int n_chk = 0;
    int n_fail = 0;

    gpio_bank #(.SW_W(8), .LED_W(8), .DATA_W(32), .DB_CNT(DB)) dut (
        .clk(clk), .rst_n(rst_n), .switches(switches), .leds(leds), .addr(addr),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference: a bit toggles once the last DB synchronised samples all disagree with it.
    logic [7:0]    m_s1, m_s2, m_deb, m_edge, m_ien, m_led, samp, nd, ne;
    logic          m_irq, m_rdv;
    logic [31:0]   m_rdd;
    logic [DB-1:0] wnd [8];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_edge = 0; m_ien = 0; m_led = 0;
            m_irq = 0; m_rdv = 0; m_rdd = 0;
            for (int i = 0; i < 8; i++) wnd[i] = '0;
        end else begin
            samp = m_s2; m_s2 = m_s1; m_s1 = switches;
            nd = m_deb;
            for (int i = 0; i < 8; i++) begin
                wnd[i] = {wnd[i][DB-2:0], samp[i]};
                if (wnd[i] == {DB{~m_deb[i]}}) nd[i] = ~m_deb[i];
            end
            m_rdv = rd_en;
            if (rd_en)
                m_rdd = {24'h0, addr == 0 ? m_deb : addr == 1 ? m_led : addr == 2 ? m_edge : m_ien};
            m_irq = |(m_edge & m_ien);
            ne = m_edge;
            if (wr_en && addr == 2) ne = ne & ~wr_data[7:0];
            ne = ne | (nd & ~m_deb);
            if (wr_en && addr == 1) m_led = wr_data[7:0];
            if (wr_en && addr == 3) m_ien = wr_data[7:0];
            m_edge = ne;
            m_deb = nd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all();
        chk("model_leds", {24'h0, leds}, {24'h0, m_led});
        chk("model_irq", {31'h0, irq}, {31'h0, m_irq});
        chk("model_rd_valid", {31'h0, rd_valid}, {31'h0, m_rdv});
        chk("model_rd_data", rd_data, m_rdd);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic idle(input int n);
        wr_en = 0; rd_en = 0;
        repeat (n) cyc();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wr_data = d; wr_en = 1; rd_en = 0;
        cyc();
        wr_en = 0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a; rd_en = 1; wr_en = 0;
        cyc();
        rd_en = 0;
        chk({tag, "_valid"}, {31'h0, rd_valid}, 32'h1);
        chk(tag, rd_data, exp);
    endtask

    initial begin
        rst_n = 1; switches = 0; addr = 0; wr_en = 0; wr_data = 0; rd_en = 0;
        #1 rst_n = 0;
        #2;
        chk("reset_leds", {24'h0, leds}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        chk("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("reset_rd_data", rd_data, 32'h0);
        switches = 8'h02;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        // debounced value lands on edge 6 after release
        repeat (5) cyc();
        addr = 0; rd_en = 1;
        cyc();
        chk("sw_edge6_pre", rd_data, 32'h0);
        chk("b2b_valid1", {31'h0, rd_valid}, 32'h1);
        cyc();
        chk("sw_edge7", rd_data, 32'h2);
        chk("b2b_valid2", {31'h0, rd_valid}, 32'h1);
        rd_en = 0;
        cyc();
        chk("rd_valid_drop", {31'h0, rd_valid}, 32'h0);
        rd_chk("edge_after_on", 2, 32'h2);
        chk("irq_disabled", {31'h0, irq}, 32'h0);

        wr(2, 32'h2);
        switches = 8'h00;
        idle(8);
        wr(3, 32'h2);
        switches = 8'h02;
        idle(5);
        chk("irq_pre_edge", {31'h0, irq}, 32'h0);
        cyc();
        chk("irq_same_cycle_edge", {31'h0, irq}, 32'h0);
        cyc();
        chk("irq_set", {31'h0, irq}, 32'h1);
        wr(2, 32'h2);
        chk("irq_hold_on_clear", {31'h0, irq}, 32'h1);
        cyc();
        chk("irq_cleared", {31'h0, irq}, 32'h0);

        switches = 8'h03;
        repeat (3) cyc();
        switches = 8'h02;
        idle(10);
        rd_chk("glitch3_sw", 0, 32'h2);
        rd_chk("glitch3_edge", 2, 32'h0);
        switches = 8'h03;
        repeat (4) cyc();
        switches = 8'h02;
        idle(12);
        rd_chk("pulse4_sw", 0, 32'h2);
        rd_chk("pulse4_edge", 2, 32'h1);

        wr(1, 32'hFFFF_FFA5);
        chk("led_write", {24'h0, leds}, 32'hA5);
        rd_chk("led_read", 1, 32'hA5);
        cyc();
        chk("rd_valid_one", {31'h0, rd_valid}, 32'h0);
        chk("rd_data_hold", rd_data, 32'hA5);
        addr = 1; wr_en = 1; rd_en = 1; wr_data = 32'h5A;
        cyc();
        wr_en = 0; rd_en = 0;
        chk("rw_same_pre", rd_data, 32'hA5);
        chk("rw_same_led", {24'h0, leds}, 32'h5A);
        wr(1, 32'hA5);
        wr(0, 32'hFF);
        rd_chk("sw_ro", 0, 32'h2);

        switches = 8'h06;
        idle(5);
        wr(2, 32'h4);
        rd_chk("set_beats_clear", 2, 32'h5);

        wr(2, 32'hFF);
        switches = 8'h00;
        idle(8);
        switches = 8'h03;
        idle(8);
        rd_chk("edge_03", 2, 32'h3);
        wr(3, 32'hFF);
        idle(2);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        chk("pre_rst_leds", {24'h0, leds}, 32'hA5);
        addr = 2; rd_en = 1; switches = 8'h00;
        #2 rst_n = 0;
        #1;
        chk("async_leds", {24'h0, leds}, 32'h0);
        chk("async_irq", {31'h0, irq}, 32'h0);
        chk("async_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("async_rd_data", rd_data, 32'h0);
        @(posedge clk);
        #1 rd_en = 0; rst_n = 1;
        cyc();
        chk("no_stale_valid", {31'h0, rd_valid}, 32'h0);
        idle(8);
        rd_chk("post_rst_edge", 2, 32'h0);
        rd_chk("post_rst_ien", 3, 32'h0);
        rd_chk("post_rst_led", 1, 32'h0);

        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) switches = 8'($urandom);
            rd_en = 1'($urandom_range(0, 1));
            wr_en = ($urandom_range(0, 3) == 0);
            addr = 2'($urandom_range(0, 3));
            wr_data = $urandom;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
